dmux_pipeline_scheduler: RTL and testbench

Front-end controller for the fixed-latency pipelined demultiplexer. Arbitrates round-robin among REQUESTERS valid/ready sources and issues one word per cycle into the demux (dmux_sel, dmux_in). Gates issue on per-output credits, because the demux cannot stall. Regenerates per-output valid strobes aligned with the demux's LATENCY-cycle output.

---
 rtl/dmux_pipeline_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dmux_pipeline_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_pipeline_scheduler.sv
// ============================================================================
// Module   : dmux_pipeline_scheduler
// Brief    : Round-robin, credit-gated issue front-end for a fixed-latency
//            pipelined demux, with regenerated per-output valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux_pipeline_scheduler #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 4,
    parameter int REQUESTERS   = 2,
    parameter int LATENCY      = 2,
    parameter int CREDITS      = 4,
    localparam int SELW        = $clog2(OUTPUT_COUNT) + 1,
    localparam int CW          = $clog2(CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQUESTERS-1:0]      req_valid,
    output logic [REQUESTERS-1:0]      req_ready,
    input  logic [REQUESTERS*WIDTH-1:0] req_data,
    input  logic [REQUESTERS*SELW-1:0] req_dest,
    output logic [SELW-1:0]            dmux_sel,
    output logic [WIDTH-1:0]           dmux_in,
    output logic [OUTPUT_COUNT-1:0]    out_valid,
    input  logic [OUTPUT_COUNT-1:0]    credit_return,
    output logic                       busy,
    output logic                       err_bad_dest,
    output logic                       err_credit_ovf
);

    localparam int              c_dw      = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam int              c_pw      = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [SELW-1:0] c_out_cnt = SELW'(OUTPUT_COUNT);
    localparam logic [CW-1:0]   c_full    = CW'(CREDITS);

    logic [WIDTH-1:0]        w_data [REQUESTERS];
    logic [SELW-1:0]         w_dest [REQUESTERS];
    logic [REQUESTERS-1:0]   w_bad;
    logic [REQUESTERS-1:0]   w_elig;
    logic [REQUESTERS-1:0]   w_ready;
    logic                    w_hs;
    logic [c_pw-1:0]         w_gidx;
    int                      w_cand;
    logic [SELW-1:0]         w_gdest;
    logic [WIDTH-1:0]        w_gdata;
    logic                    w_gbad;
    logic                    w_good;
    logic [c_pw-1:0]         w_ptr_nxt;
    logic [c_pw-1:0]         r_ptr;

    logic [CW-1:0]           r_credit [OUTPUT_COUNT];
    logic [OUTPUT_COUNT-1:0] w_dec;
    logic [OUTPUT_COUNT-1:0] w_ovf;

    // Stage 0 is the issue register; stage LATENCY drives out_valid.
    logic [LATENCY:0]        r_vld;
    logic [c_dw-1:0]         r_dst [LATENCY+1];

    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_req
            assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
            assign w_dest[gi] = req_dest[gi*SELW +: SELW];
            assign w_bad[gi]  = (w_dest[gi] >= c_out_cnt);
        end
    endgenerate

    // Out-of-range destinations are always eligible so they can be drained.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            for (int d = 0; d < OUTPUT_COUNT; d++) begin
                if ((w_dest[i] == SELW'(d)) && (r_credit[d] != '0)) begin
                    w_elig[i] = req_valid[i];
                end
            end
            if (w_bad[i]) begin
                w_elig[i] = req_valid[i];
            end
        end
    end

    always_comb begin
        w_hs    = 1'b0;
        w_gidx  = '0;
        w_cand  = 0;
        w_ready = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= REQUESTERS) begin
                w_cand = w_cand - REQUESTERS;
            end
            if (!w_hs && w_elig[w_cand[c_pw-1:0]]) begin
                w_hs   = 1'b1;
                w_gidx = w_cand[c_pw-1:0];
            end
        end
        if (w_hs) begin
            w_ready[w_gidx] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    assign w_gdest   = w_dest[w_gidx];
    assign w_gdata   = w_data[w_gidx];
    assign w_gbad    = w_bad[w_gidx];
    assign w_good    = w_hs && !w_gbad;
    assign w_ptr_nxt = (w_gidx == c_pw'(REQUESTERS - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            dmux_sel       <= '0;
            dmux_in        <= '0;
            err_bad_dest   <= 1'b0;
            err_credit_ovf <= 1'b0;
            r_vld          <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_dst[k] <= '0;
            end
        end else begin
            err_bad_dest   <= w_hs && w_gbad;
            err_credit_ovf <= |w_ovf;
            if (w_hs) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_good) begin
                dmux_sel <= w_gdest;
                dmux_in  <= w_gdata;
                r_vld[0] <= 1'b1;
                r_dst[0] <= w_gdest[c_dw-1:0];
            end else begin
                dmux_sel <= '0;
                dmux_in  <= '0;
                r_vld[0] <= 1'b0;
                r_dst[0] <= '0;
            end
            for (int k = LATENCY; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
        end
    end

    genvar gd;
    generate
        for (gd = 0; gd < OUTPUT_COUNT; gd++) begin : g_credit
            assign w_dec[gd] = w_good && (w_gdest == SELW'(gd));
            // A return against a full counter with no matching issue is dropped.
            assign w_ovf[gd] = credit_return[gd] && !w_dec[gd] && (r_credit[gd] == c_full);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_credit[gd] <= c_full;
                end else if (w_dec[gd] && !credit_return[gd]) begin
                    r_credit[gd] <= r_credit[gd] - 1'b1;
                end else if (!w_dec[gd] && credit_return[gd] && (r_credit[gd] != c_full)) begin
                    r_credit[gd] <= r_credit[gd] + 1'b1;
                end
            end

            assign out_valid[gd] = r_vld[LATENCY] && (r_dst[LATENCY] == c_dw'(gd));
        end
    endgenerate

    // Busy covers words still travelling; the stage presenting out_valid has arrived.
    generate
        if (LATENCY == 0) begin : g_busy_lat0
            assign busy = 1'b0;
        end else begin : g_busy_pipe
            assign busy = |r_vld[LATENCY-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dmux_pipeline_scheduler.sv
// ============================================================================
// Module   : tb_dmux_pipeline_scheduler
// Brief    : Directed plus randomized bench for dmux_pipeline_scheduler with a
//            cycle-level reference model (credits, RR pointer, issue history).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmux_pipeline_scheduler;

    localparam int WIDTH = 8;
    localparam int OC    = 4;
    localparam int REQ   = 2;
    localparam int LAT   = 2;
    localparam int CRED  = 4;
    localparam int SELW  = $clog2(OC) + 1;

    logic                  clk;
    logic                  rst_n;
    logic [REQ-1:0]        req_valid;
    logic [REQ-1:0]        req_ready;
    logic [REQ*WIDTH-1:0]  req_data;
    logic [REQ*SELW-1:0]   req_dest;
    logic [SELW-1:0]       dmux_sel;
    logic [WIDTH-1:0]      dmux_in;
    logic [OC-1:0]         out_valid;
    logic [OC-1:0]         credit_return;
    logic                  busy;
    logic                  err_bad_dest;
    logic                  err_credit_ovf;

    dmux_pipeline_scheduler #(
        .WIDTH        (WIDTH),
        .OUTPUT_COUNT (OC),
        .REQUESTERS   (REQ),
        .LATENCY      (LAT),
        .CREDITS      (CRED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_dest       (req_dest),
        .dmux_sel       (dmux_sel),
        .dmux_in        (dmux_in),
        .out_valid      (out_valid),
        .credit_return  (credit_return),
        .busy           (busy),
        .err_bad_dest   (err_bad_dest),
        .err_credit_ovf (err_credit_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               total;
    int               bad;
    int               cred [OC];
    int               ptr;
    int               edge_n;
    int               valid_since;
    int               hist_dest [0:4095];
    logic [WIDTH-1:0] hist_data [0:4095];
    bit               exp_bad_pulse;
    bit               exp_ovf_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs after edge e follow from the words accepted on edges e-LAT..e.
    task automatic check_outputs();
        int          e;
        logic [OC-1:0] eov;
        logic        eb;
        e   = edge_n;
        eov = '0;
        eb  = 1'b0;
        if ((e - LAT >= valid_since) && (hist_dest[e-LAT] >= 0)) eov[hist_dest[e-LAT]] = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            if ((e - k >= valid_since) && (hist_dest[e-k] >= 0)) eb = 1'b1;
        end
        chk("dmux_sel", 32'(dmux_sel), (hist_dest[e] >= 0) ? 32'(hist_dest[e]) : 32'd0);
        chk("dmux_in", 32'(dmux_in), (hist_dest[e] >= 0) ? 32'(hist_data[e]) : 32'd0);
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("busy", 32'(busy), 32'(eb));
        chk("err_bad_dest", 32'(err_bad_dest), 32'(exp_bad_pulse));
        chk("err_credit_ovf", 32'(err_credit_ovf), 32'(exp_ovf_pulse));
    endtask

    task automatic run_cycle(input logic [REQ-1:0] v, input logic [REQ*WIDTH-1:0] dat,
                             input logic [REQ*SELW-1:0] dst, input logic [OC-1:0] cr);
        int             win;
        int             i;
        int             d;
        int             gd;
        logic [REQ-1:0] er;
        req_valid     = v;
        req_data      = dat;
        req_dest      = dst;
        credit_return = cr;
        #1;
        win = -1;
        for (int k = 0; k < REQ; k++) begin
            i = (ptr + k) % REQ;
            d = int'(dst[i*SELW +: SELW]);
            if (win < 0 && v[i] && ((d >= OC) ? 1'b1 : (cred[d] > 0))) win = i;
        end
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        edge_n++;
        hist_dest[edge_n] = -1;
        hist_data[edge_n] = '0;
        exp_bad_pulse     = 1'b0;
        exp_ovf_pulse     = 1'b0;
        gd                = -1;
        if (win >= 0) begin
            ptr = (win + 1) % REQ;
            d   = int'(dst[win*SELW +: SELW]);
            if (d >= OC) begin
                exp_bad_pulse = 1'b1;
            end else begin
                gd                = d;
                hist_dest[edge_n] = d;
                hist_data[edge_n] = dat[win*WIDTH +: WIDTH];
            end
        end
        for (int c = 0; c < OC; c++) begin
            if (gd == c && cr[c]) begin
                cred[c] = cred[c];
            end else if (gd == c) begin
                cred[c]--;
            end else if (cr[c]) begin
                if (cred[c] == CRED) exp_ovf_pulse = 1'b1;
                else cred[c]++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid     = '0;
        credit_return = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dmux_sel", 32'(dmux_sel), 32'd0);
        chk("rst_dmux_in", 32'(dmux_in), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_bad", 32'(err_bad_dest), 32'd0);
        chk("rst_err_ovf", 32'(err_credit_ovf), 32'd0);
        for (int c = 0; c < OC; c++) cred[c] = CRED;
        ptr = 0;
        @(posedge clk);
        edge_n++;
        hist_dest[edge_n] = -1;
        hist_data[edge_n] = '0;
        valid_since       = edge_n;
        exp_bad_pulse     = 1'b0;
        exp_ovf_pulse     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    logic [REQ-1:0]       rv;
    logic [REQ*WIDTH-1:0] rd;
    logic [REQ*SELW-1:0]  rs;
    logic [OC-1:0]        rc;

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_dest      = '0;
        credit_return = '0;
        ptr           = 0;
        edge_n        = 0;
        valid_since   = 1;
        exp_bad_pulse = 1'b0;
        exp_ovf_pulse = 1'b0;
        for (int c = 0; c < OC; c++) cred[c] = CRED;
        for (int k = 0; k < 4096; k++) begin
            hist_dest[k] = -1;
            hist_data[k] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_dmux_sel", 32'(dmux_sel), 32'd0);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Single word: src0 -> dest 2, strobe two cycles after dmux_in.
        run_cycle(2'b01, {8'h00, 8'hA5}, {3'd0, 3'd2}, 4'b0000);
        chk("single_sel", 32'(dmux_sel), 32'd2);
        chk("single_in", 32'(dmux_in), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        run_cycle(2'b00, '0, '0, 4'b0000);
        chk("single_busy2", 32'(busy), 32'd1);
        run_cycle(2'b00, '0, '0, 4'b0000);
        chk("single_ov", 32'(out_valid), 32'h4);
        chk("single_busy3", 32'(busy), 32'd0);
        run_cycle(2'b00, '0, '0, 4'b0100);

        // Round-robin with both sources continuously valid.
        for (int n = 0; n < 6; n++) run_cycle(2'b11, {8'(8'h20 + n), 8'(8'h10 + n)}, {3'd1, 3'd0}, 4'b0011);

        // Credit exhaustion on dest 3 while src1 keeps flowing to dest 0.
        for (int n = 0; n < 10; n++) run_cycle(2'b11, {8'(8'h40 + n), 8'(8'h30 + n)}, {3'd0, 3'd3}, 4'b0001);
        run_cycle(2'b01, {8'h00, 8'h3F}, {3'd0, 3'd3}, 4'b1000);
        run_cycle(2'b01, {8'h00, 8'h3E}, {3'd0, 3'd3}, 4'b0000);
        for (int n = 0; n < 4; n++) run_cycle(2'b00, '0, '0, 4'b1000);

        // Issue to dest 1 together with its return; return to a full dest 0.
        run_cycle(2'b01, {8'h00, 8'h77}, {3'd0, 3'd1}, 4'b0011);
        chk("simul_ovf", 32'(err_credit_ovf), 32'd1);

        // Out-of-range destination.
        run_cycle(2'b01, {8'h00, 8'h99}, {3'd0, 3'd5}, 4'b0000);
        chk("bad_pulse", 32'(err_bad_dest), 32'd1);
        chk("bad_sel", 32'(dmux_sel), 32'd0);
        for (int n = 0; n < 3; n++) run_cycle(2'b00, '0, '0, 4'b0000);

        // Reset with two words in flight.
        run_cycle(2'b11, {8'h55, 8'hAA}, {3'd2, 3'd0}, 4'b0000);
        run_cycle(2'b11, {8'h56, 8'hAB}, {3'd2, 3'd0}, 4'b0000);
        do_reset();
        for (int n = 0; n < 4; n++) run_cycle(2'b00, '0, '0, 4'b0000);

        // Randomized traffic, including out-of-range dests and spurious returns.
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                do_reset();
            end else begin
                rv = REQ'($urandom_range(0, 3));
                rd = (REQ*WIDTH)'($urandom);
                rs = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
                for (int c = 0; c < OC; c++) rc[c] = ($urandom_range(0, 2) == 0);
                run_cycle(rv, rd, rs, rc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
